// File: rtl/modn_ctr_ctrl.sv
// modn_ctr_ctrl: sequencing controller for a mod-N counter datapath.
// A single-clock prescaler produces a one-cycle clock-enable for the
// counter. The modulus and divider arrive over a valid/ready handshake.
// Runs are continuous or one-shot under start/stop commands.
// Optional feature macro: MODN_CTRL_WRAPCNT_EN adds an 8-bit saturating
// wrap counter output (wrap_cnt).
module modn_ctr_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DIV_WIDTH   = 21,
  parameter int DEFAULT_N   = 10,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_mod,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_oneshot,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIDTH-1:0]     ctr_val,
  output logic                 ctr_en,
  output logic                 ctr_clr,
  output logic [WIDTH-1:0]     ctr_mod,
  output logic                 wrap,
  output logic                 done,
`ifdef MODN_CTRL_WRAPCNT_EN
  output logic [7:0]           wrap_cnt,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A modulus of zero is treated as one so the counter always has a legal range.
  function automatic logic [WIDTH-1:0] mod_eff_f(input logic [WIDTH-1:0] m);
    if (m == {WIDTH{1'b0}}) begin
      mod_eff_f = WIDTH'(1);
    end else begin
      mod_eff_f = m;
    end
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mod_eff;
  logic [WIDTH-1:0]     r_mod_last;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_oneshot;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_cfg_ready;
  logic                 r_busy;
  logic                 r_ctr_clr;
  logic                 r_done;
  logic                 w_at_top;
  logic                 w_ctr_en;
  logic                 w_wrap;
  logic                 w_cfg_take;

  assign w_at_top   = (r_div_cnt == r_div);
  assign w_cfg_take = (r_state == S_IDLE) & cfg_valid;

  // Next-state decode plus the combinational enable/wrap strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_en    = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARM: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // stop suppresses the enable in the same cycle it is seen
        w_ctr_en = w_at_top & ~stop;
        w_wrap   = w_ctr_en & (ctr_val == r_mod_last);
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_wrap & r_oneshot) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_ctr_clr   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_ctr_clr   <= (w_state_nxt == S_ARM);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Configuration latch; only open while idle so a busy source must hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mod_eff  <= mod_eff_f(WIDTH'(DEFAULT_N));
      r_mod_last <= mod_eff_f(WIDTH'(DEFAULT_N)) - WIDTH'(1);
      r_div      <= DIV_WIDTH'(DEFAULT_DIV);
      r_oneshot  <= 1'b0;
    end else if (w_cfg_take) begin
      r_mod_eff  <= mod_eff_f(cfg_mod);
      r_mod_last <= mod_eff_f(cfg_mod) - WIDTH'(1);
      r_div      <= cfg_div;
      r_oneshot  <= cfg_oneshot;
    end else begin
      r_mod_eff  <= r_mod_eff;
      r_mod_last <= r_mod_last;
      r_div      <= r_div;
      r_oneshot  <= r_oneshot;
    end
  end

  // Prescaler: counts 0..r_div while running, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= {DIV_WIDTH{1'b0}};
    end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
      if (w_at_top) begin
        r_div_cnt <= {DIV_WIDTH{1'b0}};
      end else begin
        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
      end
    end else begin
      r_div_cnt <= {DIV_WIDTH{1'b0}};
    end
  end

`ifdef MODN_CTRL_WRAPCNT_EN
  logic [7:0] r_wrap_cnt;

  // Saturating wrap counter, cleared each time a run is armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap_cnt <= 8'd0;
    end else if (r_state == S_ARM) begin
      r_wrap_cnt <= 8'd0;
    end else if (w_wrap && (r_wrap_cnt != 8'd255)) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end else begin
      r_wrap_cnt <= r_wrap_cnt;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign ctr_clr   = r_ctr_clr;
  assign done      = r_done;
  assign ctr_mod   = r_mod_eff;
  assign ctr_en    = w_ctr_en;
  assign wrap      = w_wrap;

endmodule

// File: doc/modn_ctr_ctrl.md
# modn_ctr_ctrl

Sequencing controller for the mod-N counter datapath. Replaces the free-running, derived-clock scheme with a single-clock-domain prescaler that drives a one-cycle clock-enable into the counter. Accepts a modulus/divider configuration over a valid/ready handshake and runs the counter continuously or one-shot under start/stop commands. It reports each wrap and one-shot completion to the surrounding logic.

## Interface
- WIDTH, 4, counter width; modulus and counter value are WIDTH bits
- DIV_WIDTH, 21, prescaler divider width
- DEFAULT_N, 10, modulus after reset
- DEFAULT_DIV, 0, divider after reset

- clk  in  1  single system clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_mod  in  WIDTH  modulus N
- cfg_div  in  DIV_WIDTH  enable period minus one
- cfg_oneshot  in  1  1 = stop after first wrap
- start  in  1  begin run (IDLE only)
- stop  in  1  abort run
- ctr_val  in  WIDTH  current value from the mod-N counter
- ctr_en  out  1  counter clock-enable pulse
- ctr_clr  out  1  counter synchronous clear
- ctr_mod  out  WIDTH  registered modulus to counter
- wrap  out  1  counter wraps this cycle
- done  out  1  one-shot complete pulse
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch mod/div/oneshot.
  - On start, go to ARM.
  - If cfg_valid and start arrive in the same cycle, the new config is used for the run.
- ARM: ctr_clr=1, prescaler cleared; next state is RUN.
- RUN:
  - The prescaler div_cnt counts 0..div_reg and then returns to 0.
  - ctr_en = (div_cnt==div_reg) & !stop.
  - wrap = ctr_en & (ctr_val == mod_eff-1).
- Modulus: mod_eff = (mod_reg==0) ? 1 : mod_reg. With mod_eff=1, every ctr_en is a wrap. ctr_mod outputs mod_eff.
- One-shot: the wrap cycle moves the FSM to DONE. done=1 in DONE, then IDLE.
- Continuous: remain in RUN until stop.
- stop:
  - In ARM or RUN: IDLE next cycle, and any ctr_en in that same cycle is suppressed.
  - In IDLE or DONE: ignored.
- start outside IDLE is ignored. cfg_valid outside IDLE is not accepted (cfg_ready=0) and must be held by the source.
- Reset values:
  - state=IDLE, cfg_ready=1, busy=0.
  - ctr_en=0, ctr_clr=0, wrap=0, done=0.
  - mod_reg=DEFAULT_N, div_reg=DEFAULT_DIV, oneshot_reg=0, div_cnt=0.
- Reset mid-run: the FSM returns to IDLE on the next edge with no done pulse. The counter is not cleared until the next ARM.

## Timing
- start sampled at edge S:
  - ARM (ctr_clr=1) during cycle S+1.
  - RUN from S+2.
  - First ctr_en at S+2+div_reg; thereafter every div_reg+1 cycles.
- ctr_en, wrap: combinational from state/div_cnt/ctr_val/stop, valid in the cycle the counter is enabled.
- Counter latency: the counter updates ctr_val on the edge ending a ctr_en cycle.
- Wrap in cycle W (one-shot):
  - done=1 and busy=1 in W+1.
  - IDLE with cfg_ready=1 in W+2.
- stop in cycle T: busy=0 from T+1.
- cfg_ready, busy: decoded from the state register, with no combinational path from inputs.
- Prescaler:
  - div_cnt holds 0 outside RUN.
  - The DIV_WIDTH wrap of div_cnt is unreachable, since div_cnt ≤ div_reg.

## Configuration
- MODN_CTRL_WRAPCNT_EN:
  - Defined: adds output wrap_cnt (8 bits), which clears in ARM, increments on each wrap, saturates at 255 and holds in IDLE. Reset value is 0.
  - Undefined: the port and logic are absent, and all other behaviour is identical.

## Test plan
- Reset, then cfg mod=10, div=0, continuous, start at S, with the bench modelling the counter -> ctr_clr at S+1, ctr_en every cycle from S+2, wrap at S+11, S+21; stop at S+25 -> ctr_en=0 at S+25, busy=0 at S+26.
- cfg mod=4, div=3, oneshot, start at S -> ctr_en at S+5, S+9, S+13, S+17; wrap at S+17; done at S+18; cfg_ready=1 at S+19.
- cfg_valid while busy with mod=7 -> cfg_ready=0, mod_reg unchanged; accepted in the first IDLE cycle; next run wraps every 7 enables.
- mod=0, div=1, continuous -> ctr_mod=1, wrap on every ctr_en (every 2nd cycle); stop coinciding with ctr_en -> that ctr_en and wrap suppressed.
- rst asserted mid-RUN -> next cycle: IDLE, all outputs at reset values, mod_reg=10, no done pulse; with MODN_CTRL_WRAPCNT_EN, wrap_cnt=0 and saturates at 255 after 300 wraps with mod=1, div=0.
